product_divider: RTL and testbench



---
 rtl/product_divider_if.sv | 25 ++
 rtl/product_divider.sv | 139 +++++++++++++
 tb/tb_product_divider.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/product_divider_if.sv
// rtl/product_divider_if.sv - operand/result handshake bundle for product_divider
interface product_divider_if #(
  parameter int W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   product;
  logic [W-1:0]     factor;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid, product, factor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, div0
  );

  modport slave (
    input  in_valid, product, factor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, div0
  );
endinterface

// File: rtl/product_divider.sv
// rtl/product_divider.sv - 2W/W restoring divider, one quotient bit per cycle; PRODUCT_DIVIDER_ROUND_EN adds round-to-nearest
module product_divider #(
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  product_divider_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic [W-1:0]  prem;
  logic [W-1:0]  shf;
  logic [W-1:0]  dvsr;
  logic [CW-1:0] cnt;

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic          ovf_q;
  logic          div0_q;

  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  prem_nxt;
  logic [W-1:0]  shf_nxt;
  logic          last;
  logic [W-1:0]  quo_fin;
  logic          ovf_fin;

  // The partial remainder stays below the divisor, so only the shifted
  // value needs the extra bit; the difference always fits back into W bits.
  always_comb begin
    shifted  = {prem, shf[W-1]};
    ge       = shifted >= {1'b0, dvsr};
    prem_nxt = ge ? (shifted[W-1:0] - dvsr) : shifted[W-1:0];
    shf_nxt  = {shf[W-2:0], ge};
    last     = (cnt == CNT_LAST);
  end

`ifdef PRODUCT_DIVIDER_ROUND_EN
  localparam logic [W-1:0] QUO_ONE = W'(1);
  logic round_up;
  logic sat;

  always_comb begin
    round_up = {prem_nxt, 1'b0} >= {1'b0, dvsr};
    sat      = &shf_nxt;
    quo_fin  = shf_nxt;
    ovf_fin  = 1'b0;
    if (round_up) begin
      if (sat) begin
        quo_fin = '1;
        ovf_fin = 1'b1;
      end else begin
        quo_fin = shf_nxt + QUO_ONE;
      end
    end
  end
`else
  always_comb begin
    quo_fin = shf_nxt;
    ovf_fin = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      prem   <= '0;
      shf    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dvsr <= bus.factor;
            cnt  <= '0;
            if (bus.factor == '0) begin
              quo_q  <= '1;
              rem_q  <= '0;
              div0_q <= 1'b1;
              ovf_q  <= 1'b0;
              state  <= S_DONE;
            end else if (bus.product[2*W-1:W] >= bus.factor) begin
              quo_q  <= '1;
              rem_q  <= '0;
              div0_q <= 1'b0;
              ovf_q  <= 1'b1;
              state  <= S_DONE;
            end else begin
              prem  <= bus.product[2*W-1:W];
              shf   <= bus.product[W-1:0];
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          prem <= prem_nxt;
          shf  <= shf_nxt;
          cnt  <= cnt + CNT_ONE;
          if (last) begin
            quo_q  <= quo_fin;
            rem_q  <= prem_nxt;
            ovf_q  <= ovf_fin;
            div0_q <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_product_divider.sv
// tb/tb_product_divider.sv - table and scoreboard bench for product_divider
module tb_product_divider;

  typedef struct {
    logic [31:0] p;
    logic [15:0] f;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        div0;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  product_divider_if #(.W(16)) pif ();

  product_divider #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [15:0] f, input logic [15:0] q,
                              input logic [15:0] r, input logic ovf, input logic div0, input int lat);
    vec_t v;
    v.p = p; v.f = f; v.q = q; v.r = r; v.ovf = ovf; v.div0 = div0; v.lat = lat;
    return v;
  endfunction

  // Reference built from plain integer division, independent of the shift/subtract loop.
  function automatic vec_t model(input logic [31:0] p, input logic [15:0] f);
    logic [31:0] q32;
    logic [31:0] r32;
    if (f == 16'd0) return mk(p, f, 16'hFFFF, 16'd0, 1'b0, 1'b1, 1);
    if (p[31:16] >= f) return mk(p, f, 16'hFFFF, 16'd0, 1'b1, 1'b0, 1);
    q32 = p / {16'd0, f};
    r32 = p % {16'd0, f};
`ifdef PRODUCT_DIVIDER_ROUND_EN
    if ((r32 * 2) >= {16'd0, f}) begin
      if (q32 == 32'h0000_FFFF) return mk(p, f, 16'hFFFF, r32[15:0], 1'b1, 1'b0, 17);
      q32 = q32 + 1;
    end
`endif
    return mk(p, f, q32[15:0], r32[15:0], 1'b0, 1'b0, 17);
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!pif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    vec_t e;
    int   lat;
    @(negedge clk);
    pif.product  = v.p;
    pif.factor   = v.f;
    pif.in_valid = 1'b1;
    check({name, ".in_ready"}, {31'd0, pif.in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    pif.in_valid = 1'b0;
    wait_valid(lat);
    e = sb.pop_front();
    check({name, ".lat"}, lat, e.lat);
    check({name, ".q"}, {16'd0, pif.quotient}, {16'd0, e.q});
    check({name, ".r"}, {16'd0, pif.remainder}, {16'd0, e.r});
    check({name, ".flags"}, {30'd0, pif.ovf, pif.div0}, {30'd0, e.ovf, e.div0});
    pif.out_ready = 1'b1;
    @(negedge clk);
    pif.out_ready = 1'b0;
    check({name, ".ready_after"}, {30'd0, pif.in_ready, pif.out_valid}, 32'd2);
  endtask

  initial begin
    logic [15:0] hold_q;
    logic [15:0] hold_r;
    int          lat;
    logic [15:0] rf;
    logic [15:0] rh;
    logic [15:0] rl;

`ifdef PRODUCT_DIVIDER_ROUND_EN
    tbl[0] = mk(32'd3125,      16'd25,     16'd125,    16'd0,      1'b0, 1'b0, 17);
    tbl[1] = mk(32'd20,        16'd7,      16'd3,      16'd6,      1'b0, 1'b0, 17);
    tbl[2] = mk(32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17);
    tbl[3] = mk(32'h0001_0000, 16'd1,      16'hFFFF,   16'd0,      1'b1, 1'b0, 1);
    tbl[4] = mk(32'hFFFE_FFFF, 16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b1, 1'b0, 17);
    tbl[5] = mk(32'd1234,      16'd0,      16'hFFFF,   16'd0,      1'b0, 1'b1, 1);
    tbl[6] = mk(32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 17);
    tbl[7] = mk(32'hFFFF_FFFF, 16'hFFFF,   16'hFFFF,   16'd0,      1'b1, 1'b0, 1);
    tbl[8] = mk(32'h0000_FFFF, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0, 17);
    tbl[9] = mk(32'd7,         16'd2,      16'd4,      16'd1,      1'b0, 1'b0, 17);
`else
    tbl[0] = mk(32'd3125,      16'd25,     16'd125,    16'd0,      1'b0, 1'b0, 17);
    tbl[1] = mk(32'd20,        16'd7,      16'd2,      16'd6,      1'b0, 1'b0, 17);
    tbl[2] = mk(32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17);
    tbl[3] = mk(32'h0001_0000, 16'd1,      16'hFFFF,   16'd0,      1'b1, 1'b0, 1);
    tbl[4] = mk(32'hFFFE_FFFF, 16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, 1'b0, 17);
    tbl[5] = mk(32'd1234,      16'd0,      16'hFFFF,   16'd0,      1'b0, 1'b1, 1);
    tbl[6] = mk(32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 17);
    tbl[7] = mk(32'hFFFF_FFFF, 16'hFFFF,   16'hFFFF,   16'd0,      1'b1, 1'b0, 1);
    tbl[8] = mk(32'h0000_FFFF, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0, 17);
    tbl[9] = mk(32'd7,         16'd2,      16'd3,      16'd1,      1'b0, 1'b0, 17);
`endif

    pif.in_valid  = 1'b0;
    pif.out_ready = 1'b0;
    pif.product   = '0;
    pif.factor    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.hs", {30'd0, pif.in_ready, pif.out_valid}, 32'd2);
    check("reset.qr", {pif.quotient, pif.remainder}, 32'd0);
    check("reset.flags", {30'd0, pif.ovf, pif.div0}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      rf = 16'($urandom_range(1, 65535));
      rh = 16'($urandom % rf);
      rl = 16'($urandom);
      run_op(model({rh, rl}, rf), $sformatf("rnd%0d", i));
    end

    // Back-pressure: result held, new request ignored while DONE.
    @(negedge clk);
    pif.product = 32'd100; pif.factor = 16'd7; pif.in_valid = 1'b1;
    @(negedge clk);
    pif.product = 32'd3125; pif.factor = 16'd25;
    wait_valid(lat);
    check("bp.lat", lat, 17);
    hold_q = pif.quotient;
    hold_r = pif.remainder;
    check("bp.q", {16'd0, hold_q}, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d", i), {pif.quotient, pif.remainder}, {hold_q, hold_r});
      check($sformatf("bp.busy%0d", i), {30'd0, pif.in_ready, pif.out_valid}, 32'd1);
    end
    pif.out_ready = 1'b1;
    pif.in_valid  = 1'b0;
    @(negedge clk);
    pif.out_ready = 1'b0;
    check("bp.release", {30'd0, pif.in_ready, pif.out_valid}, 32'd2);
    repeat (3) @(negedge clk);
    check("bp.no_accept", {30'd0, pif.in_ready, pif.out_valid}, 32'd2);

    // Reset in the middle of RUN aborts the operation.
    pif.product = 32'd3125; pif.factor = 16'd25; pif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pif.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("rr.running", {30'd0, pif.in_ready, pif.out_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rr.hs", {30'd0, pif.in_ready, pif.out_valid}, 32'd2);
    check("rr.qr", {pif.quotient, pif.remainder}, 32'd0);
    check("rr.flags", {30'd0, pif.ovf, pif.div0}, 32'd0);
    run_op(tbl[1], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
